// File: rtl/arbitro_vc.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | arbitro_vc : strict-priority VC0/VC1 arbiter with starvation guard,       |
// |              routing words to D0/D1 with per-destination counters.        |
// | Revision   : 1.0                                                          |
// +---------------------------------------------------------------------------+
module arbitro_vc #(
  parameter int BITBUS    = 6,
  parameter int DEST_BIT  = 4,
  parameter int MAX_BURST = 3,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_in,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [BITBUS-1:0] vc0_data,
  input  logic [BITBUS-1:0] vc1_data,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [BITBUS-1:0] data_out,
  output logic [CNT_W-1:0]  d0_count,
  output logic [CNT_W-1:0]  d1_count,
  output logic [1:0]        arb_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_VC0 = 2'd1,
    ST_GNT_VC1 = 2'd2,
    ST_BLOCKED = 2'd3
  } arb_state_t;

  localparam logic [CNT_W-1:0] C_MAX_BURST = CNT_W'(MAX_BURST);

  arb_state_t        state_q;
  logic              d0_push_q, d1_push_q;
  logic [BITBUS-1:0] data_q;
  logic [CNT_W-1:0]  d0_cnt_q, d1_cnt_q;
  logic [CNT_W-1:0]  burst_q, burst_d;

  logic              w_vc0_elig, w_vc1_elig;
  logic              w_gnt0, w_gnt1, w_any;
  logic [BITBUS-1:0] w_word;
  logic              w_dst;

  // A VC is eligible only if the destination its head word targets has room.
  assign w_vc0_elig = !reset && active_in && !vc0_empty &&
                      !(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
  assign w_vc1_elig = !reset && active_in && !vc1_empty &&
                      !(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);

  assign w_gnt0 = w_vc0_elig && (!w_vc1_elig || (burst_q != C_MAX_BURST));
  assign w_gnt1 = w_vc1_elig && !w_gnt0;
  assign w_any  = w_gnt0 || w_gnt1;
  assign w_word = w_gnt1 ? vc1_data : vc0_data;
  assign w_dst  = w_word[DEST_BIT];

  assign vc0_pop = w_gnt0;
  assign vc1_pop = w_gnt1;

  // Burst counter only advances while VC1 is actually being held off.
  always_comb begin
    burst_d = burst_q;
    if (w_gnt1) begin
      burst_d = '0;
    end else if (w_gnt0) begin
      if (!w_vc1_elig)                 burst_d = '0;
      else if (burst_q != C_MAX_BURST) burst_d = burst_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
      data_q    <= '0;
      d0_cnt_q  <= '0;
      d1_cnt_q  <= '0;
      burst_q   <= '0;
    end else begin
      d0_push_q <= w_any && !w_dst;
      d1_push_q <= w_any &&  w_dst;
      burst_q   <= burst_d;
      if (w_any)           data_q   <= w_word;
      if (w_any && !w_dst) d0_cnt_q <= d0_cnt_q + CNT_W'(1);
      if (w_any &&  w_dst) d1_cnt_q <= d1_cnt_q + CNT_W'(1);
      if (w_gnt0)
        state_q <= ST_GNT_VC0;
      else if (w_gnt1)
        state_q <= ST_GNT_VC1;
      else if (active_in && (!vc0_empty || !vc1_empty))
        state_q <= ST_BLOCKED;
      else
        state_q <= ST_IDLE;
    end
  end

  assign d0_push   = d0_push_q;
  assign d1_push   = d1_push_q;
  assign data_out  = data_q;
  assign d0_count  = d0_cnt_q;
  assign d1_count  = d1_cnt_q;
  assign arb_state = state_q;

endmodule
`default_nettype wire
